muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO; owns the HI/LO registers.
- Sits beside the EX stage. Accepts one operation at a time from ID/EX.
- Raises a stall request toward the hazard logic while an operation is in flight and a later instruction needs the unit or HI/LO.
- Lets the pipeline run freely past long operations otherwise.

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit: owns HI/LO and sequences MULT/MULTU/DIV/DIVU over WIDTH
// cycles plus one sign-fixup cycle, and asks the hazard logic to stall dependent instructions.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_neg     = operand_a[WIDTH-1];
    assign b_neg     = operand_b[WIDTH-1];
    assign a_mag     = (is_signed && a_neg) ? -operand_a : operand_a;
    assign b_mag     = (is_signed && b_neg) ? -operand_b : operand_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, b_q};

    assign prod_fix = neg_quot_q ? -acc_q : acc_q;
    assign quot_fix = neg_quot_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        b_d        = b_q;
        is_div_d   = is_div_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op_valid && !op[2]) begin
                    is_div_d = op[1];
                    count_d  = '0;
                    state_d  = StRun;
                    // Divide by zero: raw dividend falls out as the remainder, no fixup.
                    if (op[1] && (operand_b == '0)) begin
                        acc_d      = {{WIDTH{1'b0}}, operand_a};
                        b_d        = '0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                    end else begin
                        acc_d      = {{WIDTH{1'b0}}, a_mag};
                        b_d        = b_mag;
                        neg_quot_d = is_signed && (a_neg ^ b_neg);
                        neg_rem_d  = is_signed && op[1] && a_neg;
                    end
                end else if (op_valid && (op == 3'd4)) begin
                    hi_d = operand_a;
                end else if (op_valid && (op == 3'd5)) begin
                    lo_d = operand_a;
                end
            end
            StRun: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            is_div_q   <= is_div_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign stall_req = busy && (hilo_rd || op_valid);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
